// File: rtl/OoO_pkg.sv
// OoO_pkg: shared core types plus the scoreboard entry format and default sizing.
package OoO_pkg;
  localparam int SB_ENTRIES  = 8;
  localparam int SB_WB_PORTS = 2;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] result;
  } decoder_t;
  typedef struct packed {
    logic     issued;
    logic     done;
    decoder_t sbe;
  } sb_entry_t;
endpackage

// File: rtl/scoreboard.sv
// scoreboard: in-order retirement buffer tagging issued instructions and collecting results by id.
module scoreboard
  import OoO_pkg::*;
#(
  parameter int NR_ENTRIES  = SB_ENTRIES,
  parameter int NR_WB_PORTS = SB_WB_PORTS,
  localparam int IdW        = $clog2(NR_ENTRIES)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  decoder_t                          issue_instr_i,
  input  logic                              issue_valid_i,
  output logic                              issue_ready_o,
  output logic [IdW-1:0]                    issue_id_o,
  input  logic [NR_WB_PORTS-1:0]            wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][IdW-1:0]   wb_id_i,
  input  logic [NR_WB_PORTS-1:0][31:0]      wb_result_i,
  output decoder_t                          commit_instr_o,
  input  logic                              commit_ack_i
);
  sb_entry_t      r_mem [NR_ENTRIES];
  logic [IdW-1:0] r_head, r_tail;
  logic [IdW:0]   r_count;
  sb_entry_t      w_mem [NR_ENTRIES];
  logic [IdW-1:0] w_head, w_tail;
  logic [IdW:0]   w_count;
  logic           w_head_vld, w_issue, w_retire;
  assign w_head_vld    = r_mem[r_head].issued & r_mem[r_head].done;
  assign issue_ready_o = r_count != (IdW+1)'(NR_ENTRIES);
  assign issue_id_o    = r_tail;
  assign w_issue       = issue_valid_i & issue_ready_o;
  assign w_retire      = commit_ack_i & w_head_vld;
  always_comb begin
    commit_instr_o       = r_mem[r_head].sbe;
    commit_instr_o.valid = w_head_vld;
  end
  always_comb begin
    w_mem   = r_mem;
    w_head  = r_head + IdW'(w_retire);
    w_tail  = r_tail + IdW'(w_issue);
    w_count = r_count + (IdW+1)'(w_issue) - (IdW+1)'(w_retire);
    // walk ports high to low so the lowest index lands last and wins
    for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
      if (wb_valid_i[p] && r_mem[wb_id_i[p]].issued) begin
        w_mem[wb_id_i[p]].sbe.result = wb_result_i[p];
        w_mem[wb_id_i[p]].done       = 1'b1;
      end
    end
    if (w_retire) begin
      w_mem[r_head].issued = 1'b0;
      w_mem[r_head].done   = 1'b0;
    end
    if (w_issue) w_mem[r_tail] = '{issued: 1'b1, done: 1'b0, sbe: issue_instr_i};
    if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        w_mem[i].issued = 1'b0;
        w_mem[i].done   = 1'b0;
      end
      w_head  = '0;
      w_tail  = '0;
      w_count = '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem   <= '{default: '0};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_mem   <= w_mem;
      r_head  <= w_head;
      r_tail  <= w_tail;
      r_count <= w_count;
    end
  end
endmodule

// File: tb/tb_scoreboard.sv
// tb_scoreboard: directed self-checking bench for the scoreboard retirement buffer.
module tb_scoreboard;
  import OoO_pkg::*;
  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  decoder_t        issue_instr;
  logic            issue_valid;
  logic            issue_ready;
  logic [2:0]      issue_id;
  logic [1:0]      wb_valid;
  logic [1:0][2:0] wb_id;
  logic [1:0][31:0] wb_result;
  decoder_t        commit_instr;
  logic            commit_ack;
  int              checks = 0;
  int              errors = 0;
  scoreboard dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_instr_i(issue_instr), .issue_valid_i(issue_valid),
    .issue_ready_o(issue_ready), .issue_id_o(issue_id),
    .wb_valid_i(wb_valid), .wb_id_i(wb_id), .wb_result_i(wb_result),
    .commit_instr_o(commit_instr), .commit_ack_i(commit_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_instr.rd = rd;
    issue_instr.pc = {27'd0, rd};
    tick();
    issue_valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_instr = '0; issue_valid = 1'b0;
    wb_valid = '0; wb_id = '0; wb_result = '0; commit_ack = 1'b0;
    #3;
    chk("rst_ready", issue_ready, 1);
    chk("rst_id", issue_id, 0);
    chk("rst_valid", commit_instr.valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("idle_valid", commit_instr.valid, 0);
    // three issues, out-of-order writebacks, in-order commit
    chk("id_first", issue_id, 0);
    issue(5'd1);
    chk("head_rd1_shown", commit_instr.rd, 1);
    chk("head_not_done", commit_instr.valid, 0);
    issue(5'd2);
    issue(5'd3);
    chk("id_after3", issue_id, 3);
    commit_ack = 1'b1;
    wb_valid = 2'b01; wb_id[0] = 3'd2; wb_result[0] = 32'hC;
    tick();
    chk("no_commit_yet", commit_instr.valid, 0);
    wb_id[0] = 3'd0; wb_result[0] = 32'hA;
    chk("no_bypass", commit_instr.valid, 0);
    tick();
    wb_id[0] = 3'd1; wb_result[0] = 32'hB;
    chk("c1_valid", commit_instr.valid, 1);
    chk("c1_rd", commit_instr.rd, 1);
    chk("c1_res", commit_instr.result, 32'hA);
    tick();
    wb_valid = '0;
    chk("c2_valid", commit_instr.valid, 1);
    chk("c2_rd", commit_instr.rd, 2);
    chk("c2_res", commit_instr.result, 32'hB);
    tick();
    chk("c3_valid", commit_instr.valid, 1);
    chk("c3_rd", commit_instr.rd, 3);
    chk("c3_res", commit_instr.result, 32'hC);
    tick();
    commit_ack = 1'b0;
    chk("empty_valid", commit_instr.valid, 0);
    chk("empty_count", dut.r_count, 0);
    // fill to full from a flushed state
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) issue(5'(10 + i));
    chk("full_ready", issue_ready, 0);
    chk("full_count", dut.r_count, 8);
    chk("full_id_wrap", issue_id, 0);
    issue_valid = 1'b1; issue_instr.rd = 5'd31;
    tick();
    chk("ninth_count", dut.r_count, 8);
    chk("ninth_id", issue_id, 0);
    wb_valid = 2'b01; wb_id[0] = 3'd0; wb_result[0] = 32'h55;
    tick();
    wb_valid = '0;
    chk("full_head_res", commit_instr.result, 32'h55);
    chk("full_head_rd", commit_instr.rd, 10);
    commit_ack = 1'b1;
    chk("ready_no_lookahead", issue_ready, 0);
    tick();
    commit_ack = 1'b0;
    chk("ready_after_retire", issue_ready, 1);
    chk("count_after_retire", dut.r_count, 7);
    chk("wrap_id", issue_id, 0);
    tick();
    issue_valid = 1'b0;
    chk("wrap_count", dut.r_count, 8);
    chk("wrap_tail", issue_id, 1);
    chk("wrap_head", dut.r_head, 1);
    // simultaneous issue and retire at count 4
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) issue(5'(20 + i));
    wb_valid = 2'b01; wb_id[0] = 3'd0; wb_result[0] = 32'h20;
    tick();
    wb_valid = '0;
    chk("pre_count4", dut.r_count, 4);
    issue_valid = 1'b1; issue_instr.rd = 5'd24; commit_ack = 1'b1;
    tick();
    issue_valid = 1'b0; commit_ack = 1'b0;
    chk("ir_count", dut.r_count, 4);
    chk("ir_head", dut.r_head, 1);
    chk("ir_tail", issue_id, 5);
    // same-id writeback on both ports, then a writeback to an idle entry
    wb_valid = 2'b11; wb_id[0] = 3'd1; wb_id[1] = 3'd1;
    wb_result[0] = 32'h11; wb_result[1] = 32'h22;
    tick();
    wb_valid = '0;
    chk("prio_valid", commit_instr.valid, 1);
    chk("prio_res", commit_instr.result, 32'h11);
    wb_valid = 2'b01; wb_id[0] = 3'd5; wb_result[0] = 32'h77;
    tick();
    wb_valid = '0;
    chk("drop_wb", dut.r_mem[5].done, 0);
    // flush overrides a concurrent issue, writeback and ack
    issue(5'd30);
    chk("pre_flush_count", dut.r_count, 5);
    flush = 1'b1; issue_valid = 1'b1; issue_instr.rd = 5'd9; commit_ack = 1'b1;
    wb_valid = 2'b01; wb_id[0] = 3'd2; wb_result[0] = 32'h99;
    #1;
    chk("flush_cycle_valid", commit_instr.valid, 1);
    tick();
    flush = 1'b0; issue_valid = 1'b0; commit_ack = 1'b0; wb_valid = '0;
    chk("flush_count", dut.r_count, 0);
    chk("flush_id", issue_id, 0);
    chk("flush_valid", commit_instr.valid, 0);
    chk("flush_ready", issue_ready, 1);
    // asynchronous reset mid-stream
    issue(5'd7);
    issue(5'd8);
    wb_valid = 2'b01; wb_id[0] = 3'd0; wb_result[0] = 32'h44;
    tick();
    wb_valid = '0;
    chk("pre_rst_valid", commit_instr.valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", commit_instr.valid, 0);
    chk("arst_id", issue_id, 0);
    chk("arst_ready", issue_ready, 1);
    chk("arst_count", dut.r_count, 0);
    #10 rst_n = 1'b1;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
